// File: rtl/mlp_train_sequencer.sv
// mlp_train_sequencer
//
// Synthesizable training/evaluation controller for a Perceptron/Layer model.
// It walks the Data example index through NUM_EPOCHS epochs. Each epoch is a
// training pass, optionally followed by a scored evaluation pass over the
// training set. A final scored test pass over the test set ends the run.
// Predictions come back PRED_LATENCY cycles after the example index changes.
// They are matched against the expected targets captured when the example
// was issued, and hits are counted per epoch and for the test pass.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   begin a run; only honoured in IDLE or DONE
//   abort          in   return to IDLE on the next cycle (beats start)
//   threshold      in   signed class boundary
//   prediction     in   OUTPUT_UNITS x DATA_W signed model outputs
//   expected       in   OUTPUT_UNITS x DATA_W signed targets for the current example
//   example        out  Data example index
//   training       out  weight-update enable to the model
//   busy           out  high outside IDLE/DONE
//   done           out  high in DONE until the next start
//   phase          out  0 idle, 1 train, 2 eval, 3 test
//   epoch          out  current epoch, 0-based
//   epoch_done     out  one-cycle pulse at the end of each epoch
//   epoch_correct  out  eval-pass correct count, valid with epoch_done
//   test_correct   out  test-pass correct count, valid while done
module mlp_train_sequencer #(
  parameter int OUTPUT_UNITS = 1,
  parameter int NUM_TRAIN    = 600,
  parameter int NUM_TEST     = 400,
  parameter int NUM_EPOCHS   = 10,
  parameter int PRED_LATENCY = 1,
  parameter int EVAL_TRAIN   = 1,
  parameter int DATA_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [DATA_W-1:0]              threshold,
  input  logic [OUTPUT_UNITS*DATA_W-1:0] prediction,
  input  logic [OUTPUT_UNITS*DATA_W-1:0] expected,
  output logic [31:0]                    example,
  output logic                           training,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     phase,
  output logic [31:0]                    epoch,
  output logic                           epoch_done,
  output logic [31:0]                    epoch_correct,
  output logic [31:0]                    test_correct
);

  typedef enum logic [2:0] {
    IDLE, TRAIN, EVAL, DRAIN_E, TEST, DRAIN_T, DONE
  } state_t;

  localparam int          PW         = OUTPUT_UNITS * DATA_W;
  localparam logic [31:0] LAST_TRAIN = 32'(NUM_TRAIN - 1);
  localparam logic [31:0] FIRST_TEST = 32'(NUM_TRAIN);
  localparam logic [31:0] LAST_TEST  = 32'(NUM_TRAIN + NUM_TEST - 1);
  localparam logic [31:0] LAST_DRAIN = 32'(PRED_LATENCY - 1);
  localparam logic [31:0] LAST_EPOCH = 32'(NUM_EPOCHS - 1);
  localparam logic [31:0] TRAIN_MAX  = 32'(NUM_TRAIN);
  localparam logic [31:0] TEST_MAX   = 32'(NUM_TEST);

  state_t                  state, state_next;
  logic                    issue, epoch_end, last_epoch;
  logic [31:0]             drain_cnt, eval_count, eval_count_nxt;
  logic [PRED_LATENCY-1:0] pipe_valid, pipe_test;
  logic [PW-1:0]           pipe_exp [PRED_LATENCY];
  logic                    agree, hit, eval_hit, test_hit;

  assign last_epoch = (epoch == LAST_EPOCH);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the outputs that depend only on the current state.
  // issue marks a cycle whose example must be scored later. epoch_end marks
  // the final cycle of an epoch, which is the last drain cycle when an eval
  // pass runs and the last train cycle when it does not. abort overrides
  // every transition and also suppresses issue and epoch_end, so an aborted
  // epoch never pulses.
  always_comb begin
    state_next = state;
    training   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    phase      = 2'd0;
    issue      = 1'b0;
    epoch_end  = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state == DONE);
        if (start) state_next = (NUM_EPOCHS == 0) ? TEST : TRAIN;
      end
      TRAIN: begin
        training = 1'b1;
        phase    = 2'd1;
        if (example == LAST_TRAIN) begin
          if (EVAL_TRAIN != 0) begin
            state_next = EVAL;
          end else begin
            epoch_end  = 1'b1;
            state_next = last_epoch ? TEST : TRAIN;
          end
        end
      end
      EVAL: begin
        phase = 2'd2;
        issue = 1'b1;
        if (example == LAST_TRAIN) state_next = DRAIN_E;
      end
      DRAIN_E: begin
        phase = 2'd2;
        if (drain_cnt == LAST_DRAIN) begin
          epoch_end  = 1'b1;
          state_next = last_epoch ? TEST : TRAIN;
        end
      end
      TEST: begin
        phase = 2'd3;
        issue = 1'b1;
        if (example == LAST_TEST) state_next = DRAIN_T;
      end
      DRAIN_T: begin
        phase = 2'd3;
        if (drain_cnt == LAST_DRAIN) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      issue      = 1'b0;
      epoch_end  = 1'b0;
    end
  end

  // A prediction is correct only when every channel lands on the same side
  // of the threshold as its delayed target (signed compare).
  always_comb begin
    agree = 1'b1;
    for (int i = 0; i < OUTPUT_UNITS; i++) begin
      if (($signed(prediction[i*DATA_W +: DATA_W]) < $signed(threshold)) !=
          ($signed(pipe_exp[PRED_LATENCY-1][i*DATA_W +: DATA_W]) < $signed(threshold)))
        agree = 1'b0;
    end
  end

  assign hit            = pipe_valid[PRED_LATENCY-1] && agree && !abort;
  assign eval_hit       = hit && !pipe_test[PRED_LATENCY-1];
  assign test_hit       = hit && pipe_test[PRED_LATENCY-1];
  assign eval_count_nxt = (eval_hit && (eval_count < TRAIN_MAX)) ? eval_count + 32'd1 : eval_count;

  // Datapath: example index, epoch counter, score pipeline and counters.
  // The score pipeline carries a valid flag, a test/eval tag and the targets
  // of every issued example. At each epoch end, epoch_correct takes the
  // running eval count, including a hit that lands in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      example       <= '0;
      epoch         <= '0;
      epoch_done    <= 1'b0;
      epoch_correct <= '0;
      test_correct  <= '0;
      eval_count    <= '0;
      drain_cnt     <= '0;
      pipe_valid    <= '0;
      pipe_test     <= '0;
      for (int i = 0; i < PRED_LATENCY; i++) pipe_exp[i] <= '0;
    end else begin
      epoch_done <= 1'b0;
      if ((state_next == state) && ((state == DRAIN_E) || (state == DRAIN_T)))
        drain_cnt <= drain_cnt + 32'd1;
      else
        drain_cnt <= '0;

      if (abort) begin
        pipe_valid <= '0;
        pipe_test  <= '0;
      end else begin
        pipe_valid[0] <= issue;
        pipe_test[0]  <= (state == TEST);
        pipe_exp[0]   <= expected;
        for (int i = PRED_LATENCY - 1; i > 0; i--) begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_test[i]  <= pipe_test[i-1];
          pipe_exp[i]   <= pipe_exp[i-1];
        end

        eval_count <= eval_count_nxt;
        if (test_hit && (test_correct < TEST_MAX))
          test_correct <= test_correct + 32'd1;

        case (state)
          IDLE, DONE: begin
            if (start) begin
              example      <= (NUM_EPOCHS == 0) ? FIRST_TEST : '0;
              epoch        <= '0;
              test_correct <= '0;
            end
          end
          TRAIN: begin
            if (example != LAST_TRAIN) begin
              example <= example + 32'd1;
            end else if (EVAL_TRAIN != 0) begin
              example    <= '0;
              eval_count <= '0;
            end
          end
          EVAL, TEST: begin
            if (state_next == state) example <= example + 32'd1;
          end
          default: ;
        endcase

        if (epoch_end) begin
          example       <= last_epoch ? FIRST_TEST : '0;
          epoch         <= epoch + 32'd1;
          epoch_done    <= 1'b1;
          epoch_correct <= (EVAL_TRAIN != 0) ? eval_count_nxt : '0;
        end
      end
    end
  end

endmodule
